// File: rtl/dfr_feedback_reservoir.sv
// Delayed-feedback reservoir delay loop: valid-qualified virtual-node shift line
// with runtime loop length and saturating, gain-scaled tail-to-head feedback.
module dfr_feedback_reservoir #(
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_NODES  = 10,
  parameter  int GAIN_WIDTH = 16,
  parameter  int GAIN_FRAC  = 8,
  localparam int LEN_W      = $clog2(MAX_NODES + 1),
  localparam int IDX_W      = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic [LEN_W-1:0]             cfg_len,
  input  logic signed [GAIN_WIDTH-1:0] cfg_gain,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         din_valid,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         dout_valid,
  output logic [IDX_W-1:0]             node_idx,
  output logic                         frame_done
);

  localparam int PW = DATA_WIDTH + GAIN_WIDTH;
  localparam int SW = PW + 1;

  logic signed [DATA_WIDTH-1:0] node [MAX_NODES];
  logic [LEN_W-1:0]             len_q;
  logic [LEN_W-1:0]             len_load;
  logic signed [DATA_WIDTH-1:0] tail;
  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         fb;
  logic signed [SW-1:0]         sum;
  logic signed [DATA_WIDTH-1:0] sat_sum;
  logic [IDX_W-1:0]             last_idx;
  logic                         wrap;

  // Tail is the node at position len_q-1; a decoded mux keeps indexing in range.
  always_comb begin
    tail = '0;
    for (int unsigned k = 0; k < MAX_NODES; k++) begin
      if (LEN_W'(k + 1) == len_q) tail = node[k];
    end
  end

  // Full-precision product; arithmetic shift floors toward -inf.
  always_comb begin
    prod = PW'(tail) * PW'(cfg_gain);
    fb   = prod >>> GAIN_FRAC;
    sum  = SW'(din) + SW'(fb);
  end

  // In range when all bits above the data sign bit agree with it.
  always_comb begin
    if ((&sum[SW-1:DATA_WIDTH-1]) || !(|sum[SW-1:DATA_WIDTH-1]))
      sat_sum = sum[DATA_WIDTH-1:0];
    else if (sum[SW-1])
      sat_sum = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      sat_sum = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end

  always_comb begin
    if (cfg_len == '0)
      len_load = LEN_W'(1);
    else if (cfg_len > LEN_W'(MAX_NODES))
      len_load = LEN_W'(MAX_NODES);
    else
      len_load = cfg_len;
  end

  always_comb begin
    last_idx = IDX_W'(len_q - LEN_W'(1));
    wrap     = (node_idx == last_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < MAX_NODES; k++) node[k] <= '0;
      len_q      <= LEN_W'(MAX_NODES);
      node_idx   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else if (clear) begin
      for (int unsigned k = 0; k < MAX_NODES; k++) node[k] <= '0;
      len_q      <= len_load;
      node_idx   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else if (din_valid) begin
      node[0] <= sat_sum;
      // Positions beyond the active length are forced to zero so they never feed back.
      for (int unsigned k = 1; k < MAX_NODES; k++)
        node[k] <= (LEN_W'(k) < len_q) ? node[k-1] : '0;
      dout       <= tail;
      dout_valid <= 1'b1;
      node_idx   <= wrap ? '0 : node_idx + IDX_W'(1);
      frame_done <= wrap;
    end else begin
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dfr_feedback_reservoir.sv
// Directed bench for dfr_feedback_reservoir: default 32-bit instance plus a
// 16-bit instance for saturation vectors.
module tb_dfr_feedback_reservoir;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic [3:0]         cfg_len;
  logic signed [15:0] cfg_gain;
  logic signed [31:0] din;
  logic signed [15:0] din16;
  logic               din_valid;
  logic signed [31:0] dout;
  logic signed [15:0] dout16;
  logic               dout_valid, dv16;
  logic [3:0]         node_idx, idx16;
  logic               frame_done, fd16;

  int errors = 0;
  int checks = 0;

  dfr_feedback_reservoir dut (
    .clk(clk), .rst(rst), .clear(clear), .cfg_len(cfg_len), .cfg_gain(cfg_gain),
    .din(din), .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid),
    .node_idx(node_idx), .frame_done(frame_done)
  );

  dfr_feedback_reservoir #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .clear(clear), .cfg_len(cfg_len), .cfg_gain(cfg_gain),
    .din(din16), .din_valid(din_valid), .dout(dout16), .dout_valid(dv16),
    .node_idx(idx16), .frame_done(fd16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic signed [31:0] d, input logic c);
    din_valid = v;
    din       = d;
    din16     = d[15:0];
    clear     = c;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic clr(input logic [3:0] len);
    cfg_len = len;
    cyc(1'b0, 0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; cfg_len = '0; cfg_gain = '0;
    din = '0; din16 = '0; din_valid = 1'b0;
    #3;
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_idx", node_idx, 0);
    check("rst_fd", frame_done, 0);
    check("rst_dout16", dout16, 0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // 1) plain delay line, length 10
    cfg_gain = 0;
    clr(4'd10);
    check("t1_clr_valid", dout_valid, 0);
    for (int i = 1; i <= 25; i++) begin
      cyc(1'b1, i, 1'b0);
      check($sformatf("t1_dout%0d", i), dout, (i <= 10) ? 0 : i - 10);
      check($sformatf("t1_fd%0d", i), frame_done, (i % 10 == 0) ? 1 : 0);
      if (i <= 3) check($sformatf("t1_valid%0d", i), dout_valid, 1);
    end
    check("t1_idx", node_idx, 5);

    // 2) unity feedback, length 3, constant input
    cfg_gain = 256;
    clr(4'd3);
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, 5, 1'b0);
      check($sformatf("t2_dout%0d", i), dout, 5 * ((i - 1) / 3));
      check($sformatf("t2_idx%0d", i), node_idx, i % 3);
    end

    // 3) saturation on the 16-bit instance
    cfg_gain = 256;
    clr(4'd1);
    cyc(1'b1, 32'h7000, 1'b0); check("t3_p1", dout16, 0);
    cyc(1'b1, 32'h7000, 1'b0); check("t3_p2", dout16, 28672);
    cyc(1'b1, 32'h7000, 1'b0); check("t3_p3", dout16, 32767);
    cyc(1'b1, 0, 1'b0);        check("t3_p4", dout16, 32767);
    clr(4'd1);
    cyc(1'b1, -28672, 1'b0);   check("t3_n1", dout16, 0);
    cyc(1'b1, -28672, 1'b0);   check("t3_n2", dout16, -28672);
    cyc(1'b1, 0, 1'b0);        check("t3_n3", dout16, -32768);

    // 4) half gain, floor of -1.5
    cfg_gain = 128;
    clr(4'd1);
    cyc(1'b1, -3, 1'b0); check("t4_o1", dout, 0);
    cyc(1'b1, 0, 1'b0);  check("t4_o2", dout, -3);
    cyc(1'b1, 0, 1'b0);  check("t4_o3", dout, -2);

    // 5) gaps in din_valid freeze state
    cfg_gain = 0;
    clr(4'd2);
    cyc(1'b1, 7, 1'b0);  check("t5_a1", dout, 0);
    cyc(1'b1, 8, 1'b0);  check("t5_a2_fd", frame_done, 1);
    cyc(1'b1, 9, 1'b0);  check("t5_a3", dout, 7);
    check("t5_a3_idx", node_idx, 1);
    cyc(1'b0, 55, 1'b0);
    check("t5_g1_valid", dout_valid, 0);
    check("t5_g1_dout", dout, 7);
    check("t5_g1_idx", node_idx, 1);
    cyc(1'b0, 66, 1'b0);
    check("t5_g2_fd", frame_done, 0);
    cyc(1'b1, 10, 1'b0); check("t5_a4", dout, 8);
    check("t5_a4_valid", dout_valid, 1);
    check("t5_a4_fd", frame_done, 1);

    // 6) length clamps, clear vs din_valid, async reset mid-frame
    clr(4'd0);
    cyc(1'b1, 4, 1'b0);  check("t6_len0_o1", dout, 0);
    check("t6_len0_fd", frame_done, 1);
    cyc(1'b1, 5, 1'b0);  check("t6_len0_o2", dout, 4);
    check("t6_len0_idx", node_idx, 0);
    cfg_len = 4'd1;
    cyc(1'b1, 99, 1'b1);
    check("t6_cv_valid", dout_valid, 0);
    check("t6_cv_dout", dout, 0);
    cyc(1'b1, 0, 1'b0);  check("t6_cv_drop", dout, 0);
    clr(4'd15);
    for (int i = 1; i <= 11; i++) cyc(1'b1, 100 + i, 1'b0);
    check("t6_len15_dout", dout, 101);
    check("t6_len15_idx", node_idx, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_dout", dout, 0);
    check("t6_rst_valid", dout_valid, 0);
    check("t6_rst_idx", node_idx, 0);
    check("t6_rst_fd", frame_done, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= 11; i++) begin
      cyc(1'b1, (i == 1) ? 3 : 0, 1'b0);
      if (i == 1) check("t6_post_idx", node_idx, 1);
    end
    check("t6_post_len", dout, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
